// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: built-in self-test sequencer for a 32-bit adder.
// It drives 8 directed operand pairs, then NUM_RANDOM pairs from a Galois
// LFSR. Each pair is held for SETTLE_CYCLES cycles and is then compared
// once against the 33-bit reference sum. The sequencer counts the
// mismatches, and that count saturates.
// Optional build macro ADDER_BIST_FAIL_CAPTURE_EN: when it is defined, the
// block registers the first failing vector and its observed sum. When it is
// undefined, fail_a, fail_b and fail_sum are tied to zero.
module adder_bist_ctrl #(
    parameter int NUM_RANDOM    = 24,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] dut_a,
    output logic [31:0] dut_b,
    input  logic [32:0] dut_sum,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] fail_a,
    output logic [31:0] fail_b,
    output logic [32:0] fail_sum
);

    localparam int          NUM_VECTORS = 8 + NUM_RANDOM;
    localparam int          IDX_W       = $clog2(NUM_VECTORS + 1);
    localparam logic [31:0] LFSR_SEED   = 32'hACE1_2468;
    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    // Directed corner-case operands: {A, B}
    function automatic logic [63:0] directed_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    return {32'h0000_0001, 32'h0000_0001};
            3'd1:    return {32'h7FFF_FFFF, 32'h0000_0001};
            3'd2:    return {32'hFFFF_FFFF, 32'h0000_0001};
            3'd3:    return {32'hFFFF_FFFF, 32'hFFFF_FFFF};
            3'd4:    return {32'h8000_0000, 32'h8000_0000};
            3'd5:    return {32'hA5A5_A5A5, 32'h5A5A_5A5A};
            3'd6:    return {32'hF0F0_F0F0, 32'h0F0F_0F0F};
            default: return {32'h0000_0000, 32'h0000_0000};
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         settle_q, settle_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [15:0]        err_q, err_d;

    logic               start_run;
    logic               mismatch;
    logic               last_vec;
    logic [IDX_W-1:0]   next_idx;
    logic [31:0]        lfsr_adv;
    logic [32:0]        exp_sum;

    assign start_run = start && (state_q == S_IDLE || state_q == S_DONE);
    assign exp_sum   = {1'b0, a_q} + {1'b0, b_q};
    assign mismatch  = (state_q == S_CHECK) && (dut_sum != exp_sum);
    assign last_vec  = (idx_q == IDX_W'(NUM_VECTORS - 1));
    assign next_idx  = idx_q + IDX_W'(1);
    assign lfsr_adv  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge value of every other, independent of order.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            lfsr_q   <= LFSR_SEED;
            a_q      <= '0;
            b_q      <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            lfsr_q   <= lfsr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            err_q    <= err_d;
        end
    end

    // Next-state: launch, settle countdown, check-and-advance
    always_comb begin
        // NOTE: every signal gets a hold default first; a path that left one
        // unassigned would infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        lfsr_d   = lfsr_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_run) begin
                    state_d    = S_SETTLE;
                    idx_d      = '0;
                    settle_d   = SETTLE_LOAD;
                    lfsr_d     = LFSR_SEED;
                    {a_d, b_d} = directed_vec(3'd0);
                    err_d      = '0;
                end
            end
            S_SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            S_CHECK: begin
                if (mismatch && err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
                if (last_vec) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_SETTLE;
                    idx_d    = next_idx;
                    settle_d = SETTLE_LOAD;
                    if (next_idx < IDX_W'(8)) begin
                        {a_d, b_d} = directed_vec(next_idx[2:0]);
                    end else begin
                        lfsr_d = lfsr_adv;
                        a_d    = lfsr_adv;
                        b_d    = {lfsr_adv[18:0], lfsr_adv[31:19]};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_a     = a_q;
    assign dut_b     = b_q;
    assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == 16'd0);
    assign err_count = err_q;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    logic [31:0] fail_a_q;
    logic [31:0] fail_b_q;
    logic [32:0] fail_sum_q;

    // First-mismatch capture, cleared by a new run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_sum_q <= '0;
        end else if (start_run) begin
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_sum_q <= '0;
        end else if (mismatch && err_q == 16'd0) begin
            fail_a_q   <= a_q;
            fail_b_q   <= b_q;
            fail_sum_q <= dut_sum;
        end
    end

    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_sum = fail_sum_q;
`else
    assign fail_a   = '0;
    assign fail_b   = '0;
    assign fail_sum = '0;
`endif

endmodule

// File: doc/adder_bist_ctrl.md
ADDER_BIST_CTRL -- requirements
Module: adder_bist_ctrl

Interface
REQ-001 SHALL have parameter NUM_RANDOM, default 24, number of pseudo-random vectors run after the directed set (legal 1..4096).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, clock cycles each vector is held before sampling dut_sum (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE or DONE.
REQ-006 SHALL have port dut_a  output  32  operand A driven to adder under test.
REQ-007 SHALL have port dut_b  output  32  operand B driven to adder under test.
REQ-008 SHALL have port dut_sum  input  33  sum returned by adder under test (combinational or pipelined within SETTLE_CYCLES).
REQ-009 SHALL have port busy  output  1  high in SETTLE or CHECK.
REQ-010 SHALL have port done  output  1  high in DONE.
REQ-011 SHALL have port pass  output  1  high in DONE when err_count is 0, else low.
REQ-012 SHALL have port err_count  output  16  mismatching vectors in current/last run.
REQ-013 SHALL have ports fail_a  output  32, fail_b  output  32, fail_sum  output  33  first failing vector and its observed sum.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-015 SHALL, on start=1 in IDLE or DONE, load vector 0 into dut_a/dut_b, clear err_count and fail capture, reseed LFSR, load settle counter to SETTLE_CYCLES-1, enter SETTLE.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL in SETTLE decrement the settle counter each cycle and enter CHECK when it is 0.
REQ-018 SHALL in CHECK compare dut_sum to the internally computed 33-bit zero-extended dut_a+dut_b; mismatch increments err_count.
REQ-019 SHALL saturate err_count at 16'hFFFF.
REQ-020 SHALL in CHECK load the next vector and re-enter SETTLE, or enter DONE after the last vector; each vector takes exactly SETTLE_CYCLES+1 cycles.
REQ-021 SHALL run directed vectors 0..7 in order: 00000001+00000001, 7FFFFFFF+00000001, FFFFFFFF+00000001, FFFFFFFF+FFFFFFFF, 80000000+80000000, A5A5A5A5+5A5A5A5A, F0F0F0F0+0F0F0F0F, 00000000+00000000.
REQ-022 SHALL generate random vectors 8..8+NUM_RANDOM-1 from a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seed 32'hACE12468, stepped once per random vector before use; A = LFSR state, B = state rotated left 13.
REQ-023 SHALL hold dut_a/dut_b stable through SETTLE and CHECK, and hold the last vector in DONE.
REQ-024 SHALL assert done (96 cycles for defaults) exactly (8+NUM_RANDOM)*(SETTLE_CYCLES+1) cycles after the start edge, held until next start.

Reset
REQ-025 SHALL on rst_n=0, immediately and at any point mid-run: state IDLE, dut_a=dut_b=0, busy=done=pass=0, err_count=0, fail_a=fail_b=0, fail_sum=0, LFSR=seed, settle counter=0.
REQ-026 SHALL not start a run on the first edge after rst_n deasserts unless start=1 is sampled.

Configuration
REQ-027 SHALL with ADDER_BIST_FAIL_CAPTURE_EN defined register dut_a, dut_b, dut_sum on the first mismatch of a run and hold them until next start or reset.
REQ-028 SHALL with ADDER_BIST_FAIL_CAPTURE_EN undefined tie fail_a, fail_b, fail_sum to 0 with no capture registers; all other behaviour unchanged.

Verification
REQ-029 SHALL cover: ideal adder (dut_sum=A+B), defaults, start pulse -> done at +96 cycles, pass=1, err_count=0, vector 3 shows dut_a=dut_b=FFFFFFFF.
REQ-030 SHALL cover: faulty adder returning A+B+1 -> err_count=32, pass=0; with macro fail_a=00000001, fail_b=00000001, fail_sum=000000003; without macro all three 0.
REQ-031 SHALL cover: start held high throughout run -> no restart; done at +96 cycles; second start in DONE restarts with identical vector sequence and err_count cleared.
REQ-032 SHALL cover: rst_n low at cycle 40 of run -> outputs zero same cycle, state IDLE; later start -> full 96-cycle run, pass=1.
REQ-033 SHALL cover: SETTLE_CYCLES=1, NUM_RANDOM=1, 1-cycle-pipelined ideal adder -> done at +18 cycles, pass=1.
